// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider: one quotient bit per clock, fixed WIDTH+1 cycle latency.
// Optional two's-complement mode (is_signed port) is enabled by defining DIV_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | WIDTH shift/compare/subtract iterations
// FIX   | sign correction, result registers loaded, done pulsed
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             signed_mode;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] r_diff;
  logic             r_ge;
  logic             dvs_zero;

`ifdef DIV_SIGNED_EN
  assign signed_mode = is_signed;
`else
  assign signed_mode = 1'b0;
`endif

  assign a_neg = signed_mode & dividend[WIDTH-1];
  assign b_neg = signed_mode & divisor[WIDTH-1];
  assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

  // Shifted partial remainder is one bit wider so the compare cannot overflow;
  // after a subtract it is always below the divisor, so WIDTH bits suffice to store it.
  assign r_shift  = {r_q, q_q[WIDTH-1]};
  assign r_ge     = (r_shift >= {1'b0, dvs_q});
  assign r_diff   = r_shift[WIDTH-1:0] - dvs_q;
  assign dvs_zero = (dvs_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = a_mag;
          dvs_d   = b_mag;
          r_d     = '0;
          cnt_d   = '0;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          state_d = CALC;
        end
      end
      CALC: begin
        r_d   = r_ge ? r_diff : r_shift[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], r_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        // Divide-by-zero keeps the all-ones quotient regardless of dividend sign.
        quot_d  = (neg_q_q && !dvs_zero) ? (~q_q + 1'b1) : q_q;
        rem_d   = neg_r_q ? (~r_q + 1'b1) : r_q;
        dbz_d   = dvs_zero;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Scoreboard bench for seq_divider32: expected results queued at acceptance, compared on done.
module tb_seq_divider32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        is_signed;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  seq_divider32 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    e.dbz = (b == 32'd0);
    e.acc = 0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Caller positions at a negedge with the DUT idle (or in its done cycle).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e     = model(a, b, s);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (prev_done) chk("done_pulse", {31'd0, done}, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          chk("busy_at_done", {31'd0, busy}, 32'd0);
          chk("latency", cyc - e.acc, 32'd33);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ua[7] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] ub[7] = '{32'd7,   32'd1,         32'd9, 32'd0,    32'd5, 32'hFFFF_FFFF, 32'd3};
    reset     = 1'b0;
    start     = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    is_signed = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      issue(ua[i], ub[i], 1'b0);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      wait_idle();
    end
    for (int i = 0; i < 6; i++) begin
      issue($urandom, (i == 0) ? 32'd1 : ($urandom >> (i * 5)), 1'b0);
      wait_idle();
    end

    // start during busy must be ignored
    issue(32'd200, 32'd9, 1'b0);
    repeat (9) @(negedge clk);
    dividend = 32'd5;
    divisor  = 32'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // start in the done cycle is accepted
    issue(32'd100, 32'd7, 1'b0);
    begin
      int n;
      n = 0;
      while (!done && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
    end
    issue(32'd1000, 32'd3, 1'b0);
    wait_idle();

    // mid-operation reset discards the operation
    issue(32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_quot", quotient, 32'd0);
    chk("mid_rst_rem", remainder, 32'd0);
    chk("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    sb.delete();
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_quot", quotient, 32'd0);

`ifdef DIV_SIGNED_EN
    begin
      logic [31:0] sa[6] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF7, 32'hFFFF_FF9C, 32'hFFFF_FFF9};
      logic [31:0] sbv[6] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF9, 32'd2};
      logic        ss[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
        issue(sa[i], sbv[i], ss[i]);
        wait_idle();
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
